// File: rtl/dcache_assoc_pkg.sv
// Shared types and helpers for the associative data cache.
package dcache_assoc_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned OFFSET_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_FILL
  } state_t;

  function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned index_w);
    return addr_w - index_w - OFFSET_W;
  endfunction

  function automatic bit ways_supported(input int unsigned ways);
    return (ways == 1) || (ways == 2);
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: tag RAM and data RAM, synchronous read, byte-enable data write.
module dcache_way
  import dcache_assoc_pkg::*;
#(
  parameter int unsigned INDEX_W = 10,
  parameter int unsigned TAG_W   = 20
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic              wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic              wr_tag_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [WORD_W-1:0] wr_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [WORD_W-1:0] rd_data
);

  localparam int unsigned SETS = 2 ** INDEX_W;

  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [WORD_W-1:0] data_mem [SETS];

  // Tag RAM: written only on a fill, read when a request is accepted.
  always_ff @(posedge clk) begin
    if (wr_en && wr_tag_en) tag_mem[wr_index] <= wr_tag;
    if (rd_en) rd_tag <= tag_mem[rd_index];
  end

  // Data RAM: byte-enable write (fill writes all bytes, write hits merge), sync read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (wr_be[b]) data_mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (rd_en) rd_data <= data_mem[rd_index];
  end

endmodule

// File: rtl/dcache_assoc.sv
// N-way (1 or 2) write-through, no-write-allocate data cache with LRU replacement.
module dcache_assoc
  import dcache_assoc_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INDEX_W = 10,
  parameter int unsigned WAYS    = 2,
  parameter int unsigned STAT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              flush,
  input  logic              cpu_oe,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_we,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_valid,
  output logic              cpu_ready,
  output logic              dram_oe,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [3:0]        dram_we,
  output logic [31:0]       dram_wdata,
  input  logic [31:0]       dram_rdata,
  input  logic              dram_valid,
  input  logic              dram_busy,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  localparam int unsigned TAG_W = tag_width(ADDR_W, INDEX_W);
  localparam int unsigned SETS  = 2 ** INDEX_W;

  if (!ways_supported(WAYS)) begin : g_bad_ways
    $error("dcache_assoc: WAYS must be 1 or 2");
  end

  state_t              state;
  logic [ADDR_W-1:0]   req_addr;
  logic [3:0]          req_we;
  logic [31:0]         req_wdata;
  logic [31:0]         fill_data;
  logic                flush_pend;
  logic [SETS-1:0]     valid [WAYS];
  logic [SETS-1:0]     lru;
  logic [TAG_W-1:0]    way_tag  [WAYS];
  logic [31:0]         way_data [WAYS];

  logic [INDEX_W-1:0]  req_index;
  logic [TAG_W-1:0]    req_tag;
  logic [WAYS-1:0]     hit_vec;
  logic                hit;
  logic                hit_way;
  logic [31:0]         hit_data;
  logic                victim;
  logic                is_read;
  logic                rd_hit;
  logic                accept;
  logic                fill_now;
  logic                flush_now;

  assign req_index = req_addr[INDEX_W+1:2];
  assign req_tag   = req_addr[ADDR_W-1:INDEX_W+2];
  assign is_read   = (req_we == 4'b0000);
  assign fill_now  = (state == S_MISS_WAIT) && dram_valid;
  assign flush_now = (state == S_IDLE) && (flush || flush_pend);

  // Tag compare, hit-way select and victim choice for the registered request.
  always_comb begin
    hit_vec = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid[w][req_index] && (way_tag[w] == req_tag);
    end
    hit     = |hit_vec;
    hit_way = 1'b0;
    if (WAYS == 2 && hit_vec[WAYS-1]) hit_way = 1'b1;
    hit_data = way_data[hit_way];
    // Lowest invalid way first; only when every way is valid does LRU decide.
    victim = 1'b0;
    if (WAYS == 2 && valid[0][req_index]) begin
      victim = valid[WAYS-1][req_index] ? lru[req_index] : 1'b1;
    end
  end

  // CPU/DRAM handshake outputs derived from the FSM state and registered request.
  always_comb begin
    rd_hit     = (state == S_LOOKUP) && is_read && hit;
    cpu_ready  = ((state == S_IDLE) || rd_hit) && !dram_busy && !flush && !flush_pend;
    accept     = cpu_oe && cpu_ready;
    cpu_valid  = rd_hit || (state == S_FILL);
    cpu_rdata  = (state == S_FILL) ? fill_data : hit_data;
    dram_oe    = ((state == S_LOOKUP) && !is_read) || ((state == S_MISS_REQ) && !dram_busy);
    dram_we    = (state == S_LOOKUP) ? req_we : 4'b0000;
    dram_addr  = req_addr;
    dram_wdata = req_wdata;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic fill_wr;
    logic merge_wr;

    assign fill_wr  = fill_now && (victim == 1'(w));
    assign merge_wr = (state == S_LOOKUP) && !is_read && hit_vec[w];

    dcache_way #(
      .INDEX_W(INDEX_W),
      .TAG_W  (TAG_W)
    ) u_way (
      .clk      (CLK),
      .rd_en    (accept),
      .rd_index (cpu_addr[INDEX_W+1:2]),
      .wr_en    (fill_wr || merge_wr),
      .wr_index (req_index),
      .wr_tag_en(fill_wr),
      .wr_tag   (req_tag),
      .wr_be    (fill_wr ? 4'b1111 : req_we),
      .wr_data  (fill_wr ? dram_rdata : req_wdata),
      .rd_tag   (way_tag[w]),
      .rd_data  (way_data[w])
    );

    // Valid bits: bulk clear on flush in IDLE, set by a fill of this way.
    always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
        valid[w] <= '0;
      end else if (flush_now) begin
        valid[w] <= '0;
      end else if (fill_wr) begin
        valid[w][req_index] <= 1'b1;
      end
    end
  end

  if (WAYS == 2) begin : g_lru
    // LRU bit names the way to evict next; any hit or fill points it at the other way.
    always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
        lru <= '0;
      end else if ((state == S_LOOKUP) && hit) begin
        lru[req_index] <= ~hit_way;
      end else if (fill_now) begin
        lru[req_index] <= ~victim;
      end
    end
  end else begin : g_no_lru
    assign lru = '0;
  end

  // Main FSM with request capture, deferred flush and saturating statistics.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state      <= S_IDLE;
      req_addr   <= '0;
      req_we     <= '0;
      req_wdata  <= '0;
      fill_data  <= '0;
      flush_pend <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      if (state == S_IDLE) flush_pend <= 1'b0;
      else if (flush)      flush_pend <= 1'b1;

      if (accept) begin
        req_addr  <= cpu_addr;
        req_we    <= cpu_we;
        req_wdata <= cpu_wdata;
      end

      case (state)
        S_IDLE: begin
          if (accept) state <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (is_read) begin
            if (hit) begin
              if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
              state <= accept ? S_LOOKUP : S_IDLE;
            end else begin
              if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
              state <= S_MISS_REQ;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_MISS_REQ: begin
          if (!dram_busy) state <= S_MISS_WAIT;
        end
        S_MISS_WAIT: begin
          if (dram_valid) begin
            fill_data <= dram_rdata;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: vector table plus multi-cycle corner sequences.
module tb_dcache_assoc;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic        flush = 1'b0;
  logic        cpu_oe = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [3:0]  cpu_we = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_valid;
  logic        cpu_ready;
  logic        dram_oe;
  logic [31:0] dram_addr;
  logic [3:0]  dram_we;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata = '0;
  logic        dram_valid = 1'b0;
  logic        dram_busy = 1'b0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always #5 CLK = ~CLK;

  dcache_assoc #(
    .ADDR_W (32),
    .INDEX_W(10),
    .WAYS   (2),
    .STAT_W (32)
  ) dut (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .flush     (flush),
    .cpu_oe    (cpu_oe),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_valid (cpu_valid),
    .cpu_ready (cpu_ready),
    .dram_oe   (dram_oe),
    .dram_addr (dram_addr),
    .dram_we   (dram_we),
    .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata),
    .dram_valid(dram_valid),
    .dram_busy (dram_busy),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  int tests = 0;
  int fails = 0;

  // DRAM model state and observation counters
  int          cyc = 0;
  int          oe_cnt = 0;
  int          rd_cmd = 0;
  int          wr_cmd = 0;
  int          val_cnt = 0;
  int          dv_at = -1;
  int          val_at = -1;
  int          lat = 0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_we = '0;
  logic [31:0] mem [int unsigned];

  // Unwritten words read back as 0xD000_xxxx with the low address half.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(int'(a[31:2]))) return mem[int'(a[31:2])];
    return 32'hD000_0000 | {16'h0000, a[15:0]};
  endfunction

  // DRAM responder: drives dram_valid on negedges, samples commands mid-cycle.
  always begin : dram_model
    logic [31:0] wv;
    @(negedge CLK);
    cyc++;
    dram_valid = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        dram_valid = 1'b1;
        dram_rdata = mem_rd(pend_addr);
        pend = 1'b0;
        dv_at = cyc;
      end else begin
        pend_cnt--;
      end
    end
    #2;
    if (cpu_valid) begin
      val_at = cyc;
      val_cnt++;
    end
    if (dram_oe) begin
      oe_cnt++;
      last_addr  = dram_addr;
      last_we    = dram_we;
      last_wdata = dram_wdata;
      if (dram_we != 4'b0000) begin
        wr_cmd++;
        wv = mem_rd(dram_addr);
        for (int b = 0; b < 4; b++) if (dram_we[b]) wv[8*b +: 8] = dram_wdata[8*b +: 8];
        mem[int'(dram_addr[31:2])] = wv;
      end else begin
        rd_cmd++;
        pend = 1'b1;
        pend_cnt = lat;
        pend_addr = dram_addr;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One CPU access; returns read data and cycles from accept to cpu_valid.
  task automatic access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata,
                        output logic [31:0] rd, output int l);
    int n;
    rd = '0;
    l = 0;
    @(negedge CLK);
    cpu_addr = addr;
    cpu_we = we;
    cpu_wdata = wdata;
    cpu_oe = 1'b1;
    n = 0;
    #1;
    while (!cpu_ready && n < 50) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (!cpu_ready) chk("accept_timeout", {31'b0, cpu_ready}, 32'd1);
    @(negedge CLK);
    cpu_oe = 1'b0;
    #1;
    l = 1;
    if (we == 4'b0000) begin
      while (!cpu_valid && l < 50) begin
        @(negedge CLK);
        #1;
        l++;
      end
      if (!cpu_valid) chk("read_timeout", {31'b0, cpu_valid}, 32'd1);
      rd = cpu_rdata;
      #2;
    end else begin
      @(negedge CLK);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    bit          miss;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  initial begin : main
    logic [31:0] rd;
    int l, rd0, wr0, oe0, v0, n, issued, run, maxrun, vseen;

    mem[32'h100 >> 2] = 32'hCAFE0001;

    tbl[0]  = '{32'h0000_0100, 4'b0000, 32'h0,          1'b1, 32'hCAFE0001};
    tbl[1]  = '{32'h0000_0100, 4'b0000, 32'h0,          1'b0, 32'hCAFE0001};
    tbl[2]  = '{32'h0000_0100, 4'b0011, 32'h0000BEEF,   1'b0, 32'h0};
    tbl[3]  = '{32'h0000_0100, 4'b0000, 32'h0,          1'b0, 32'hCAFEBEEF};
    tbl[4]  = '{32'h0000_0100, 4'b1100, 32'h12340000,   1'b0, 32'h0};
    tbl[5]  = '{32'h0000_0100, 4'b0000, 32'h0,          1'b0, 32'h1234BEEF};
    tbl[6]  = '{32'h0000_0200, 4'b1111, 32'h12345678,   1'b0, 32'h0};
    tbl[7]  = '{32'h0000_0200, 4'b0000, 32'h0,          1'b1, 32'h12345678};
    tbl[8]  = '{32'h0000_0000, 4'b0000, 32'h0,          1'b1, 32'hD0000000};
    tbl[9]  = '{32'h0000_1000, 4'b0000, 32'h0,          1'b1, 32'hD0001000};
    tbl[10] = '{32'h0000_2000, 4'b0000, 32'h0,          1'b1, 32'hD0002000};
    tbl[11] = '{32'h0000_1000, 4'b0000, 32'h0,          1'b0, 32'hD0001000};
    tbl[12] = '{32'h0000_0000, 4'b0000, 32'h0,          1'b1, 32'hD0000000};
    tbl[13] = '{32'h0000_1000, 4'b0000, 32'h0,          1'b0, 32'hD0001000};
    tbl[14] = '{32'h0000_2000, 4'b0000, 32'h0,          1'b1, 32'hD0002000};

    repeat (3) @(negedge CLK);
    RST_X = 1'b1;
    #1;
    chk("rst_hit_cnt",   hit_cnt,  32'd0);
    chk("rst_miss_cnt",  miss_cnt, 32'd0);
    chk("rst_cpu_valid", {31'b0, cpu_valid}, 32'd0);
    chk("rst_dram_oe",   {31'b0, dram_oe},   32'd0);
    chk("rst_dram_we",   {28'b0, dram_we},   32'd0);
    chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'd1);

    // Table: miss/hit/write-merge/write-miss/LRU eviction in one set
    for (int i = 0; i < NV; i++) begin
      rd0 = rd_cmd;
      wr0 = wr_cmd;
      oe0 = oe_cnt;
      access(tbl[i].addr, tbl[i].we, tbl[i].wdata, rd, l);
      if (tbl[i].we == 4'b0000) begin
        chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp);
        chk($sformatf("v%0d_dram_reads", i), rd_cmd - rd0, {31'b0, tbl[i].miss});
        if (tbl[i].miss) chk($sformatf("v%0d_fill_after_dv", i), val_at, dv_at + 1);
        else             chk($sformatf("v%0d_hit_latency", i), l, 32'd1);
      end else begin
        chk($sformatf("v%0d_dram_writes", i), wr_cmd - wr0, 32'd1);
        chk($sformatf("v%0d_dram_we", i), {28'b0, last_we}, {28'b0, tbl[i].we});
        chk($sformatf("v%0d_dram_wdata", i), last_wdata, tbl[i].wdata);
        chk($sformatf("v%0d_dram_addr", i), last_addr, tbl[i].addr);
        chk($sformatf("v%0d_no_fill", i), rd_cmd - rd0, 32'd0);
      end
      chk($sformatf("v%0d_oe_pulses", i), oe_cnt - oe0,
          (tbl[i].miss || tbl[i].we != 4'b0000) ? 32'd1 : 32'd0);
      if (i == 0) chk("t1_miss_cnt", miss_cnt, 32'd1);
    end
    chk("tbl_hit_cnt",  hit_cnt,  32'd5);
    chk("tbl_miss_cnt", miss_cnt, 32'd7);

    // Four back-to-back read hits
    oe0 = oe_cnt;
    @(negedge CLK);
    cpu_addr = 32'h100;
    cpu_we = 4'b0000;
    cpu_oe = 1'b1;
    issued = 0; run = 0; maxrun = 0; vseen = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (cpu_valid) begin
        vseen++;
        run++;
        chk($sformatf("b2b_rdata_%0d", c), cpu_rdata, 32'h1234BEEF);
      end else begin
        run = 0;
      end
      if (run > maxrun) maxrun = run;
      if (cpu_oe && cpu_ready) issued++;
      @(negedge CLK);
      if (issued == 4) cpu_oe = 1'b0;
    end
    chk("b2b_consecutive", maxrun, 32'd4);
    chk("b2b_no_dram", oe_cnt - oe0, 32'd0);
    chk("b2b_hit_cnt", hit_cnt, 32'd9);

    // Flush while a miss waits on DRAM: fill completes, then lines are gone
    lat = 4;
    rd0 = rd_cmd;
    @(negedge CLK);
    cpu_addr = 32'h3000;
    cpu_we = 4'b0000;
    cpu_oe = 1'b1;
    @(negedge CLK);
    cpu_oe = 1'b0;
    n = 0;
    while (rd_cmd == rd0 && n < 20) begin
      @(negedge CLK);
      #3;
      n++;
    end
    chk("flush_miss_issued", rd_cmd - rd0, 32'd1);
    @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    n = 0;
    #1;
    while (!cpu_valid && n < 30) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("flush_fill_valid", {31'b0, cpu_valid}, 32'd1);
    chk("flush_fill_data", cpu_rdata, 32'hD0003000);
    lat = 0;
    rd0 = rd_cmd;
    access(32'h3000, 4'b0000, 32'h0, rd, l);
    chk("flush_reread_miss", rd_cmd - rd0, 32'd1);
    chk("flush_reread_data", rd, 32'hD0003000);
    rd0 = rd_cmd;
    access(32'h100, 4'b0000, 32'h0, rd, l);
    chk("flush_other_miss", rd_cmd - rd0, 32'd1);
    chk("flush_other_data", rd, 32'h1234BEEF);

    // Flush together with cpu_oe in IDLE: request must not be taken
    @(negedge CLK);
    flush = 1'b1;
    cpu_oe = 1'b1;
    cpu_addr = 32'h100;
    cpu_we = 4'b0000;
    #1;
    chk("flush_oe_ready", {31'b0, cpu_ready}, 32'd0);
    v0 = val_cnt;
    @(negedge CLK);
    flush = 1'b0;
    cpu_oe = 1'b0;
    repeat (3) @(negedge CLK);
    #3;
    chk("flush_oe_no_valid", val_cnt - v0, 32'd0);
    chk("flush_oe_hit_cnt", hit_cnt, 32'd9);
    rd0 = rd_cmd;
    access(32'h100, 4'b0000, 32'h0, rd, l);
    chk("flush_oe_then_miss", rd_cmd - rd0, 32'd1);

    // dram_busy held for 10 cycles during MISS_REQ
    @(negedge CLK);
    cpu_addr = 32'h5000;
    cpu_we = 4'b0000;
    cpu_oe = 1'b1;
    @(negedge CLK);
    cpu_oe = 1'b0;
    dram_busy = 1'b1;
    oe0 = oe_cnt;
    repeat (10) @(negedge CLK);
    #3;
    chk("busy_no_oe", oe_cnt - oe0, 32'd0);
    @(negedge CLK);
    dram_busy = 1'b0;
    n = 0;
    #1;
    while (!cpu_valid && n < 30) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("busy_fill_valid", {31'b0, cpu_valid}, 32'd1);
    chk("busy_fill_data", cpu_rdata, 32'hD0005000);
    #2;
    chk("busy_one_oe", oe_cnt - oe0, 32'd1);

    // Reset during MISS_WAIT followed by a late dram_valid
    lat = 5;
    rd0 = rd_cmd;
    @(negedge CLK);
    cpu_addr = 32'h6000;
    cpu_we = 4'b0000;
    cpu_oe = 1'b1;
    @(negedge CLK);
    cpu_oe = 1'b0;
    n = 0;
    while (rd_cmd == rd0 && n < 20) begin
      @(negedge CLK);
      #3;
      n++;
    end
    @(negedge CLK);
    RST_X = 1'b0;
    @(negedge CLK);
    RST_X = 1'b1;
    v0 = val_cnt;
    repeat (10) @(negedge CLK);
    #3;
    chk("rst_mid_no_valid", val_cnt - v0, 32'd0);
    chk("rst_mid_hit_cnt", hit_cnt, 32'd0);
    chk("rst_mid_miss_cnt", miss_cnt, 32'd0);
    chk("rst_mid_ready", {31'b0, cpu_ready}, 32'd1);
    lat = 0;
    rd0 = rd_cmd;
    access(32'h100, 4'b0000, 32'h0, rd, l);
    chk("rst_after_miss", rd_cmd - rd0, 32'd1);
    chk("rst_after_data", rd, 32'h1234BEEF);
    chk("rst_after_miss_cnt", miss_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
